fp_addsub_ctrl_pipe: RTL and testbench

//  Pipelined, parametrised sign/exponent control for the FP add/sub datapath.
//  Per operation: resolves effective operation and result sign, applies carry and

---
 rtl/fp_addsub_ctrl_if.sv | 42 ++++
 rtl/fp_addsub_ctrl_pipe.sv | 151 +++++++++++++++
 tb/tb_fp_addsub_ctrl_pipe.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_addsub_ctrl_if.sv
// Handshake and data bundle for the FP add/sub sign/exponent control pipe.
// "slave" is the block side; "master" is the upstream producer plus downstream consumer.
interface fp_addsub_ctrl_if #(
  parameter int EXP_W   = 8,
  parameter int SHIFT_W = 8,
  parameter int TAG_W   = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [TAG_W-1:0]   in_tag;
  logic               sign1;
  logic               sign2;
  logic               opcode;
  logic               borrow;
  logic               exp_eq;
  logic               mant_lt;
  logic               mant_eq;
  logic [EXP_W-1:0]   exp_large;
  logic               carry;
  logic [SHIFT_W-1:0] norm_shift;
  logic               out_valid;
  logic               out_ready;
  logic [TAG_W-1:0]   out_tag;
  logic               eff_sub;
  logic               sign_r;
  logic [EXP_W-1:0]   exp_r;
  logic               ovf;
  logic               unf;
  logic               zero;

  modport slave (
    input  in_valid, in_tag, sign1, sign2, opcode, borrow, exp_eq, mant_lt, mant_eq,
           exp_large, carry, norm_shift, out_ready,
    output in_ready, out_valid, out_tag, eff_sub, sign_r, exp_r, ovf, unf, zero
  );

  modport master (
    output in_valid, in_tag, sign1, sign2, opcode, borrow, exp_eq, mant_lt, mant_eq,
           exp_large, carry, norm_shift, out_ready,
    input  in_ready, out_valid, out_tag, eff_sub, sign_r, exp_r, ovf, unf, zero
  );
endinterface

// File: rtl/fp_addsub_ctrl_pipe.sv
// Two-stage sign/exponent control for the FP add/sub datapath: stage 1 resolves
// effective operation and sign, stage 2 corrects the exponent and classifies the result.
module fp_addsub_ctrl_pipe #(
  parameter int EXP_W   = 8,
  parameter int SHIFT_W = 8,
  parameter int TAG_W   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_addsub_ctrl_if.slave bus
);

  // Exponent arithmetic width: wide enough that neither +carry nor -norm_shift wraps.
  localparam int EW = ((EXP_W > SHIFT_W) ? EXP_W : SHIFT_W) + 2;
  localparam logic [EW-1:0] EXP_MAX = {{(EW-EXP_W){1'b0}}, {EXP_W{1'b1}}};

  // Stage 1 registers
  logic               s1_valid_q, s1_valid_d;
  logic               s1_sign_q;
  logic               s1_eff_sub_q;
  logic               s1_cancel_q;
  logic [EXP_W-1:0]   s1_exp_q;
  logic               s1_carry_q;
  logic [SHIFT_W-1:0] s1_shift_q;
  logic [TAG_W-1:0]   s1_tag_q;

  // Stage 2 (output) registers
  logic               s2_valid_q, s2_valid_d;
  logic [TAG_W-1:0]   out_tag_q;
  logic               eff_sub_q;
  logic               sign_r_q, sign_r_d;
  logic [EXP_W-1:0]   exp_r_q, exp_r_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               zero_q, zero_d;

  logic s1_adv;
  logic in_fire;
  logic eff_sub_c;
  logic op2_big_c;
  logic cancel_c;
  logic sign_c;
  logic [EW-1:0] e_c;
  logic          e_neg;

  assign s1_adv       = !s2_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid_q || s1_adv;
  assign in_fire      = bus.in_valid && bus.in_ready;

  // Operand 2 dominates the magnitude only when it is strictly larger.
  assign eff_sub_c = bus.sign1 ^ bus.sign2 ^ bus.opcode;
  assign op2_big_c = bus.borrow | (bus.exp_eq & bus.mant_lt);
  assign cancel_c  = eff_sub_c & bus.exp_eq & bus.mant_eq;

  always_comb begin
    sign_c = bus.sign1;
    if (cancel_c) begin
      sign_c = 1'b0;
    end else if (eff_sub_c && op2_big_c) begin
      sign_c = bus.sign2 ^ bus.opcode;
    end
  end

  assign e_c   = {{(EW-EXP_W){1'b0}}, s1_exp_q}
               + {{(EW-1){1'b0}}, s1_carry_q}
               - {{(EW-SHIFT_W){1'b0}}, s1_shift_q};
  assign e_neg = e_c[EW-1];

  // Cancellation wins over any exponent range condition.
  always_comb begin
    sign_r_d = s1_sign_q;
    exp_r_d  = e_c[EXP_W-1:0];
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    zero_d   = 1'b0;
    if (s1_cancel_q) begin
      zero_d   = 1'b1;
      sign_r_d = 1'b0;
      exp_r_d  = '0;
    end else if (!e_neg && (e_c >= EXP_MAX)) begin
      ovf_d   = 1'b1;
      exp_r_d = '1;
    end else if (e_neg || (e_c == '0)) begin
      unf_d   = 1'b1;
      exp_r_d = '0;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_eff_sub_q <= 1'b0;
      s1_cancel_q  <= 1'b0;
      s1_exp_q     <= '0;
      s1_carry_q   <= 1'b0;
      s1_shift_q   <= '0;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      out_tag_q    <= '0;
      eff_sub_q    <= 1'b0;
      sign_r_q     <= 1'b0;
      exp_r_q      <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_fire) begin
        s1_sign_q    <= sign_c;
        s1_eff_sub_q <= eff_sub_c;
        s1_cancel_q  <= cancel_c;
        s1_exp_q     <= bus.exp_large;
        s1_carry_q   <= bus.carry;
        s1_shift_q   <= bus.norm_shift;
        s1_tag_q     <= bus.in_tag;
      end
      // Output data only moves when a new result advances, so it holds under stall.
      if (s1_adv && s1_valid_q) begin
        out_tag_q <= s1_tag_q;
        eff_sub_q <= s1_eff_sub_q;
        sign_r_q  <= sign_r_d;
        exp_r_q   <= exp_r_d;
        ovf_q     <= ovf_d;
        unf_q     <= unf_d;
        zero_q    <= zero_d;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.eff_sub   = eff_sub_q;
  assign bus.sign_r    = sign_r_q;
  assign bus.exp_r     = exp_r_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_fp_addsub_ctrl_pipe.sv
// Scoreboard bench for fp_addsub_ctrl_pipe: directed vectors push expected results,
// an independent monitor pops and compares each accepted output.
module tb_fp_addsub_ctrl_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   stall_seen = 0;
  bit   force_low = 1'b0;
  int   st_lo = -1;
  int   st_hi = -1;

  typedef struct {
    logic [16:0] v;
    int          issue;
    bit          lat;
  } exp_t;
  exp_t sb[$];

  fp_addsub_ctrl_if #(.EXP_W(8), .SHIFT_W(8), .TAG_W(4)) bus ();

  fp_addsub_ctrl_pipe #(.EXP_W(8), .SHIFT_W(8), .TAG_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [16:0] got;
  assign got = {bus.out_tag, bus.eff_sub, bus.sign_r, bus.exp_r, bus.ovf, bus.unf, bus.zero};

  // Consumer ready: held low on request or within a cycle window.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      bus.out_ready = !(force_low || (cyc >= st_lo && cyc <= st_hi));
    end
  end

  // Monitor: compares accepted outputs and checks hold-stability under stall.
  initial begin
    bit          stalled;
    logic [16:0] snap;
    exp_t        e;
    stalled = 1'b0;
    snap    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          n_cmp++;
          if (!bus.out_valid || got !== snap) begin
            n_mis++;
            $display("FAIL hold: valid=%0b data=%h required valid=1 data=%h", bus.out_valid, got, snap);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_mis++;
            $display("FAIL unexpected_output: data=%h required no output", got);
          end else begin
            e = sb.pop_front();
            if (got !== e.v) begin
              n_mis++;
              $display("FAIL result: got tag=%0d eff=%0b sgn=%0b exp=%0d o/u/z=%0b%0b%0b required tag=%0d eff=%0b sgn=%0b exp=%0d o/u/z=%0b%0b%0b",
                       got[16:13], got[12], got[11], got[10:3], got[2], got[1], got[0],
                       e.v[16:13], e.v[12], e.v[11], e.v[10:3], e.v[2], e.v[1], e.v[0]);
            end else begin
              $display("txn tag=%0d eff=%0b sgn=%0b exp=%0d o/u/z=%0b%0b%0b ok",
                       got[16:13], got[12], got[11], got[10:3], got[2], got[1], got[0]);
            end
            if (e.lat) begin
              n_cmp++;
              if (cyc - e.issue != 2) begin
                n_mis++;
                $display("FAIL latency: got %0d cycles required 2", cyc - e.issue);
              end
            end
          end
        end
        stalled = bus.out_valid && !bus.out_ready;
        snap    = got;
      end
    end
  end

  task automatic issue(input logic [3:0] tag, input bit s1, input bit s2, input bit op,
                       input bit brw, input bit eeq, input bit mlt, input bit meq,
                       input logic [7:0] expl, input bit cy, input logic [7:0] sh,
                       input bit x_eff, input bit x_sgn, input logic [7:0] x_exp,
                       input bit x_ovf, input bit x_unf, input bit x_zero, input bit lat);
    exp_t e;
    int   waits;
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.in_tag     = tag;
    bus.sign1      = s1;
    bus.sign2      = s2;
    bus.opcode     = op;
    bus.borrow     = brw;
    bus.exp_eq     = eeq;
    bus.mant_lt    = mlt;
    bus.mant_eq    = meq;
    bus.exp_large  = expl;
    bus.carry      = cy;
    bus.norm_shift = sh;
    #1;
    waits = 0;
    while (!bus.in_ready && waits < 100) begin
      stall_seen++;
      waits++;
      @(negedge clk);
      #1;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_mis++;
      $display("FAIL in_ready_timeout: in_ready=0 required 1 within 100 cycles");
    end else begin
      e.v     = {tag, x_eff, x_sgn, x_exp, x_ovf, x_unf, x_zero};
      e.issue = cyc;
      e.lat   = lat;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || got !== '0) begin
      n_mis++;
      $display("FAIL %s: out_valid=%0b in_ready=%0b data=%h required 0/1/0", name, bus.out_valid, bus.in_ready, got);
    end
  endtask

  initial begin
    int waits;
    bus.in_valid   = 1'b0;
    bus.in_tag     = '0;
    bus.sign1      = 1'b0;
    bus.sign2      = 1'b0;
    bus.opcode     = 1'b0;
    bus.borrow     = 1'b0;
    bus.exp_eq     = 1'b0;
    bus.mant_lt    = 1'b0;
    bus.mant_eq    = 1'b0;
    bus.exp_large  = '0;
    bus.carry      = 1'b0;
    bus.norm_shift = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    //    tag s1 s2 op brw eeq mlt meq exp  cy sh    eff sgn exp  o u z lat
    issue(1, 0, 0, 0, 0,  0,  0,  0,  127, 1, 0,    0,  0,  128, 0,0,0, 1); // 1.5+1.25
    issue(2, 0, 0, 1, 0,  1,  1,  0,  128, 0, 1,    1,  1,  127, 0,0,0, 0); // 2.0-3.0
    issue(3, 1, 1, 1, 0,  1,  0,  1,  100, 0, 0,    1,  0,  0,   0,0,1, 0); // x-x
    issue(4, 1, 1, 0, 0,  0,  0,  0,  254, 1, 0,    0,  1,  255, 1,0,0, 0); // overflow
    issue(5, 0, 1, 0, 1,  0,  0,  0,  3,   0, 5,    1,  1,  0,   0,1,0, 0); // underflow, sign kept
    issue(6, 0, 0, 0, 0,  0,  0,  0,  5,   0, 5,    0,  0,  0,   0,1,0, 0); // e == 0
    issue(7, 0, 0, 0, 0,  0,  0,  0,  254, 0, 0,    0,  0,  254, 0,0,0, 0); // largest finite
    issue(8, 0, 0, 0, 0,  0,  0,  0,  2,   0, 1,    0,  0,  1,   0,0,0, 0); // smallest normal
    issue(9, 1, 0, 1, 0,  0,  0,  0,  10,  1, 3,    0,  1,  8,   0,0,0, 0); // carry with shift
    issue(10,0, 1, 0, 0,  1,  0,  1,  254, 1, 0,    1,  0,  0,   0,0,1, 0); // cancel beats ovf
    issue(11,0, 0, 0, 0,  1,  0,  1,  100, 1, 0,    0,  0,  101, 0,0,0, 0); // x+x, no cancel
    issue(12,0, 0, 1, 0,  0,  1,  0,  50,  0, 2,    1,  0,  48,  0,0,0, 0); // mant_lt ignored
    idle(6);

    // Back-to-back burst with a 3-cycle consumer stall.
    stall_seen = 0;
    st_lo = cyc + 3;
    st_hi = cyc + 5;
    for (int t = 0; t < 8; t++) begin
      issue(4'(t), 0, 0, 0, 0, 0, 0, 0, 8'(10 + t), 0, 0, 0, 0, 8'(10 + t), 0, 0, 0, 0);
    end
    idle(8);
    n_cmp++;
    if (stall_seen == 0) begin
      n_mis++;
      $display("FAIL backpressure: in_ready low cycles=%0d required >0", stall_seen);
    end

    // Reset with two operations in flight.
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 force_low = 1'b1;
    issue(13, 1, 1, 0, 0, 0, 0, 0, 200, 1, 0, 0, 1, 201, 0, 0, 0, 0);
    issue(14, 1, 1, 0, 0, 0, 0, 0, 254, 1, 0, 0, 1, 255, 1, 0, 0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_outputs("reset_in_flight");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    force_low = 1'b0;
    issue(15, 0, 0, 0, 0, 0, 0, 0, 127, 1, 0, 0, 0, 128, 0, 0, 0, 1);
    idle(1);

    waits = 0;
    while (sb.size() != 0 && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    idle(4);
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++;
      $display("FAIL drain: %0d results outstanding required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
